// File: rtl/mips_debug_pkg.sv
// Shared state encoding, frame header and frame geometry for the MIPS debug snapshot block.
package mips_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP_WAIT,
    ST_STEP_EXEC,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Header + cycle count + PC + all latch bytes + checksum.
  function automatic int frame_len(input int len, input int cycle_w,
                                   input int n_stages, input int nb_latch);
    return 2 + cycle_w / 8 + len / 8 + n_stages * nb_latch;
  endfunction

endpackage

// File: rtl/mips_debug_snapshot_if.sv
// Byte-stream link from the snapshot serializer to the debug UART transmitter.
// A byte moves on every clock edge where out_valid && out_ready.
interface mips_debug_snapshot_if;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_byte, output out_valid, input out_ready);
  modport slave  (input out_byte, input out_valid, output out_ready);
endinterface

// File: rtl/debug_byte_serializer.sv
// Walks a frozen snapshot as header, snapshot bytes, then running XOR checksum.
// Byte presented combinationally in SEND; held stable while out_ready is low.
module debug_byte_serializer
  import mips_debug_pkg::*;
#(
  parameter int LEN      = 32,
  parameter int N_STAGES = 4,
  parameter int NB_LATCH = 8,
  parameter int CYCLE_W  = 32
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [CYCLE_W+LEN+N_STAGES*NB_LATCH*8-1:0] snapshot,
  input  logic                                       load,
  input  logic                                       active,
  mips_debug_snapshot_if.master                      dbg,
  output logic                                       frame_done
);

  localparam int SNAP_W = CYCLE_W + LEN + N_STAGES * NB_LATCH * 8;
  localparam int HEAD_B = (CYCLE_W + LEN) / 8;
  localparam int N_DATA = HEAD_B + N_STAGES * NB_LATCH;
  localparam int FLEN   = frame_len(LEN, CYCLE_W, N_STAGES, NB_LATCH);
  localparam int IDX_W  = $clog2(FLEN);

  logic [7:0]       data_bytes [N_DATA];
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       csum;
  logic [7:0]       cur_byte;
  logic             xfer;
  logic             is_last;

  // Cycle count and PC are already MSB-first in the snapshot; latch stages
  // sit with stage 0 in the LSBs, so each stage is re-ordered MSB-first.
  for (genvar k = 0; k < N_DATA; k++) begin : g_bytes
    if (k < HEAD_B) begin : g_head
      assign data_bytes[k] = snapshot[SNAP_W-1-8*k -: 8];
    end else begin : g_latch
      localparam int J = k - HEAD_B;
      assign data_bytes[k] =
        snapshot[(J / NB_LATCH) * NB_LATCH * 8 + (NB_LATCH - 1 - J % NB_LATCH) * 8 +: 8];
    end
  end

  assign is_last = (byte_idx == IDX_W'(FLEN - 1));

  always_comb begin
    cur_byte = FRAME_HDR;
    if (is_last) begin
      cur_byte = csum;
    end else if (byte_idx != '0) begin
      cur_byte = data_bytes[byte_idx - IDX_W'(1)];
    end
  end

  assign xfer       = active && dbg.out_ready;
  assign frame_done = xfer && is_last;

  always_ff @(posedge clk) begin
    if (!reset || load) begin
      byte_idx <= '0;
      csum     <= '0;
    end else if (xfer) begin
      if (byte_idx != '0 && !is_last) begin
        csum <= csum ^ cur_byte;
      end
      if (!is_last) begin
        byte_idx <= byte_idx + IDX_W'(1);
      end
    end
  end

  assign dbg.out_valid = active;
  assign dbg.out_byte  = active ? cur_byte : 8'h00;

endmodule

// File: rtl/mips_debug_snapshot.sv
// Gates the CPU clock-enable (run-to-halt / single-step), counts enabled cycles and
// captures a snapshot; frame starts 1 cycle after capture and stalls on out_ready.
module mips_debug_snapshot
  import mips_debug_pkg::*;
#(
  parameter int LEN      = 32,
  parameter int N_STAGES = 4,
  parameter int NB_LATCH = 8,
  parameter int CYCLE_W  = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_STAGES*NB_LATCH*8-1:0]  in_latches,
  input  logic [LEN-1:0]                  in_pc,
  input  logic                            halt_flag,
  input  logic                            mode,
  input  logic                            start,
  input  logic                            step_req,
  mips_debug_snapshot_if.master           dbg,
  output logic                            cpu_enable,
  output logic                            busy,
  output logic                            dump_done,
  output logic [CYCLE_W-1:0]              cycle_count
);

  localparam int SNAP_W = CYCLE_W + LEN + N_STAGES * NB_LATCH * 8;

  state_t            state, state_nxt;
  logic              halt_seen, halt_seen_nxt;
  logic [SNAP_W-1:0] snapshot;
  logic              frame_done;
  logic              idle_like;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);

  always_comb begin
    state_nxt     = state;
    halt_seen_nxt = halt_seen;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          halt_seen_nxt = 1'b0;
          if (mode) begin
            state_nxt = ST_STEP_WAIT;
          end else if (halt_flag) begin
            state_nxt     = ST_CAPTURE;
            halt_seen_nxt = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (halt_flag) begin
          state_nxt     = ST_CAPTURE;
          halt_seen_nxt = 1'b1;
        end
      end
      ST_STEP_WAIT: begin
        if (step_req) state_nxt = ST_STEP_EXEC;
      end
      ST_STEP_EXEC: begin
        state_nxt     = ST_CAPTURE;
        halt_seen_nxt = halt_flag;
      end
      ST_CAPTURE: state_nxt = ST_SEND;
      ST_SEND: begin
        if (frame_done) state_nxt = halt_seen ? ST_DONE : ST_STEP_WAIT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      halt_seen   <= 1'b0;
      cpu_enable  <= 1'b0;
      cycle_count <= '0;
      snapshot    <= '0;
    end else begin
      state      <= state_nxt;
      halt_seen  <= halt_seen_nxt;
      // Registered enable tracks the state being entered, so it is high exactly in RUN/STEP_EXEC.
      cpu_enable <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP_EXEC);
      if (idle_like && start) begin
        cycle_count <= '0;
      end else if (cpu_enable && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CYCLE_W'(1);
      end
      if (state == ST_CAPTURE) begin
        snapshot <= {cycle_count, in_pc, in_latches};
      end
    end
  end

  assign busy      = !idle_like;
  assign dump_done = (state == ST_DONE);

  debug_byte_serializer #(
    .LEN      (LEN),
    .N_STAGES (N_STAGES),
    .NB_LATCH (NB_LATCH),
    .CYCLE_W  (CYCLE_W)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .snapshot   (snapshot),
    .load       (state == ST_CAPTURE),
    .active     (state == ST_SEND),
    .dbg        (dbg),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_mips_debug_snapshot.sv
// Scoreboard bench for mips_debug_snapshot: frame bytes come from a byte-level model
// built from the stimulus; a negedge monitor compares every presented byte.
module tb_mips_debug_snapshot;

  localparam int LEN = 32;
  localparam int N_STAGES = 4;
  localparam int NB_LATCH = 8;
  localparam int CYCLE_W = 32;
  localparam int LAT_W = N_STAGES * NB_LATCH * 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [LAT_W-1:0] in_latches;
  logic [LEN-1:0]   in_pc;
  logic             halt_flag, mode, start, step_req;
  logic             cpu_enable, busy, dump_done;
  logic [CYCLE_W-1:0] cycle_count;

  mips_debug_snapshot_if dbg ();

  mips_debug_snapshot #(
    .LEN(LEN), .N_STAGES(N_STAGES), .NB_LATCH(NB_LATCH), .CYCLE_W(CYCLE_W)
  ) dut (
    .clk(clk), .reset(reset), .in_latches(in_latches), .in_pc(in_pc),
    .halt_flag(halt_flag), .mode(mode), .start(start), .step_req(step_req),
    .dbg(dbg), .cpu_enable(cpu_enable), .busy(busy), .dump_done(dump_done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit bp_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [LEN-1:0]   sv_pc;
  logic [LAT_W-1:0] sv_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: header, count MSB-first, PC MSB-first, stages 0..N-1 MSB-first, XOR.
  task automatic push_frame(input logic [CYCLE_W-1:0] cnt, input logic [LEN-1:0] pc,
                            input logic [LAT_W-1:0] lat);
    logic [7:0] b, cs;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = CYCLE_W / 8 - 1; i >= 0; i--) begin
      b = cnt[i*8 +: 8]; exp_q.push_back(b); cs ^= b;
    end
    for (int i = LEN / 8 - 1; i >= 0; i--) begin
      b = pc[i*8 +: 8]; exp_q.push_back(b); cs ^= b;
    end
    for (int s = 0; s < N_STAGES; s++) begin
      for (int j = NB_LATCH - 1; j >= 0; j--) begin
        b = lat[(s*NB_LATCH + j)*8 +: 8]; exp_q.push_back(b); cs ^= b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic rand_data();
    in_pc = $urandom;
    for (int i = 0; i < LAT_W / 32; i++) in_latches[i*32 +: 32] = $urandom;
  endtask

  // Monitor: every presented byte must equal the head of the expected stream.
  always @(negedge clk) begin
    if (reset && dbg.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte: got %0h expected no byte at %0t", dbg.out_byte, $time);
      end else begin
        check("frame_byte", {56'd0, dbg.out_byte}, {56'd0, exp_q[0]});
        if (dbg.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    dbg.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      dbg.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Runs until the frame has been sent; scrambles inputs after capture and optionally
  // throws start/step_req pulses at the DUT while it is sending.
  task automatic drain(input bit inject);
    int n, extra;
    bit started;
    n = 0; extra = 0; started = 1'b0;
    while (n < 3000) begin
      @(negedge clk);
      if (dbg.out_valid) started = 1'b1;
      if (cpu_enable) extra++;
      if (started && !dbg.out_valid && exp_q.size() == 0) break;
      @(posedge clk); #1;
      start = 1'b0; step_req = 1'b0;
      if (started) rand_data();
      if (inject && started && exp_q.size() > 3) begin
        start    = 1'($urandom_range(0, 1));
        step_req = 1'($urandom_range(0, 1));
      end
      n++;
    end
    check("drain_in_time", {63'd0, n < 3000}, 64'd1);
    check("no_extra_enable", extra, 0);
    start = 1'b0; step_req = 1'b0;
  endtask

  task automatic run_halt(input int k, input bit bp, input bit fresh);
    if (fresh) begin
      rand_data(); sv_pc = in_pc; sv_lat = in_latches;
    end else begin
      in_pc = sv_pc; in_latches = sv_lat;
    end
    bp_en = bp; mode = 1'b0; halt_flag = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= k; i++) begin
      if (i == k) halt_flag = 1'b1;
      @(negedge clk);
      check("run_enable", cpu_enable, 1);
      @(posedge clk); #1;
    end
    push_frame(k, sv_pc, sv_lat);
    @(negedge clk);
    check("halt_enable_off", cpu_enable, 0);
    check("halt_count", cycle_count, k);
    check("halt_busy", busy, 1);
    @(posedge clk); #1;
    halt_flag = 1'b0;
    drain(1'b1);
    check("run_dump_done", dump_done, 1);
    check("run_busy_off", busy, 0);
    check("run_count_hold", cycle_count, k);
    bp_en = 1'b0;
  endtask

  task automatic step_session();
    bp_en = 1'b0; mode = 1'b1; halt_flag = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
    @(negedge clk);
    check("step_wait_enable", cpu_enable, 0);
    check("step_wait_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      rand_data(); sv_pc = in_pc; sv_lat = in_latches;
      halt_flag = (k == 4);
      repeat ($urandom_range(1, 4)) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("step_idle_enable", cpu_enable, 0);
      end
      @(posedge clk); #1;
      step_req = 1'b1;
      @(posedge clk); #1;
      step_req = 1'b0;
      @(negedge clk);
      check("step_pulse", cpu_enable, 1);
      push_frame(k, sv_pc, sv_lat);
      @(posedge clk); #1;
      @(negedge clk);
      check("step_pulse_end", cpu_enable, 0);
      check("step_count", cycle_count, k);
      @(posedge clk); #1;
      halt_flag = 1'b0;
      drain(1'b1);
      if (k < 4) begin
        check("step_back_to_wait", {62'd0, busy, dump_done}, 64'b10);
      end else begin
        check("step_halt_done", {62'd0, busy, dump_done}, 64'b01);
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; step_req = 1'b0; halt_flag = 1'b0; mode = 1'b0;
    in_pc = '0; in_latches = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rand_data();
      start = 1'($urandom); step_req = 1'($urandom);
      halt_flag = 1'($urandom); mode = 1'($urandom);
      @(negedge clk);
      check("rst_enable", cpu_enable, 0);
      check("rst_valid", dbg.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_count", cycle_count, 0);
      check("rst_done", dump_done, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; step_req = 1'b0; halt_flag = 1'b0; mode = 1'b0;
    @(posedge clk); #1;

    run_halt(10, 1'b0, 1'b1);
    run_halt(10, 1'b1, 1'b0);
    step_session();

    // Halt already asserted at start: capture immediately with a zero count.
    rand_data(); sv_pc = in_pc; sv_lat = in_latches;
    halt_flag = 1'b1; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_frame(0, sv_pc, sv_lat);
    @(negedge clk);
    check("prehalt_enable", cpu_enable, 0);
    @(posedge clk); #1;
    halt_flag = 1'b0;
    drain(1'b0);
    check("prehalt_done", dump_done, 1);

    // Reset while byte 17 is on the link.
    rand_data(); sv_pc = in_pc; sv_lat = in_latches;
    mode = 1'b0; halt_flag = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) halt_flag = 1'b1;
      @(posedge clk); #1;
    end
    push_frame(3, sv_pc, sv_lat);
    @(posedge clk); #1;
    halt_flag = 1'b0;
    n = 0;
    while (exp_q.size() > 25 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_byte17", exp_q.size(), 25);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_valid", dbg.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_count", cycle_count, 0);
    check("abort_enable", cpu_enable, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_halt(7, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
